// File: rtl/join_fork_sync_n.sv
// join_fork_sync_n: clocked N-input join with a two-way fork.
// Each input channel buffers one token over a four-phase req/ack handshake.
// When every channel holds a token and both output channels are idle, the
// stage fires. It produces a = AND over A_MASK and b = OR over B_MASK. Each
// result is then offered on its own four-phase output channel.
// Optional macro JOIN_FORK_SYNC_EN adds a 2-flop synchroniser on lr, ra_a and
// ra_b, for use with asynchronous handshake logic.

// Single input channel: one-token buffer plus its four-phase acknowledge.
module join_fork_sync_n_chan #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_lr,
    input  logic             i_fire,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_la,
    output logic             o_full,
    output logic [WIDTH-1:0] o_buf
);
    logic             r_la;
    logic             r_full;
    logic [WIDTH-1:0] r_buf;

    // Capture a token only when empty and the previous ack has returned to
    // zero. The fire edge empties the buffer, and a channel cannot capture on
    // that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_la   <= 1'b0;
            r_full <= 1'b0;
            r_buf  <= '0;
        end else begin
            if (i_lr && !r_la && !r_full) begin
                r_buf  <= i_data;
                r_full <= 1'b1;
                r_la   <= 1'b1;
            end else begin
                if (!i_lr && r_la) r_la <= 1'b0;
                if (i_fire)        r_full <= 1'b0;
            end
        end
    end

    assign o_la   = r_la;
    assign o_full = r_full;
    assign o_buf  = r_buf;
endmodule

module join_fork_sync_n #(
    parameter int             N_IN   = 3,
    parameter int             WIDTH  = 1,
    parameter logic [N_IN-1:0] A_MASK = 3'b111,
    parameter logic [N_IN-1:0] B_MASK = 3'b101
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       lr,
    output logic [N_IN-1:0]       la,
    input  logic [N_IN*WIDTH-1:0] i_data,
    output logic                  rr_a,
    input  logic                  ra_a,
    output logic [WIDTH-1:0]      a,
    output logic                  rr_b,
    input  logic                  ra_b,
    output logic [WIDTH-1:0]      b
);
    typedef enum logic [1:0] {O_IDLE, O_REQ, O_RTZ} ostate_t;

    logic [N_IN-1:0]            w_lr;
    logic                       w_ra_a;
    logic                       w_ra_b;
    logic [N_IN-1:0]            w_full;
    logic [N_IN-1:0][WIDTH-1:0] w_buf;
    logic [WIDTH-1:0]           w_and;
    logic [WIDTH-1:0]           w_or;
    logic                       w_fire;

    ostate_t          r_st_a;
    ostate_t          r_st_b;
    logic             r_rr_a;
    logic             r_rr_b;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

`ifdef JOIN_FORK_SYNC_EN
    logic [N_IN+1:0] r_sync1;
    logic [N_IN+1:0] r_sync2;

    // Two-flop synchroniser on all incoming handshake wires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {ra_b, ra_a, lr};
            r_sync2 <= r_sync1;
        end
    end

    assign w_lr   = r_sync2[N_IN-1:0];
    assign w_ra_a = r_sync2[N_IN];
    assign w_ra_b = r_sync2[N_IN+1];
`else
    assign w_lr   = lr;
    assign w_ra_a = ra_a;
    assign w_ra_b = ra_b;
`endif

    // Fire when every buffer holds a token and both forks have finished.
    assign w_fire = (&w_full) && (r_st_a == O_IDLE) && (r_st_b == O_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_chan
            join_fork_sync_n_chan #(.WIDTH(WIDTH)) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_lr   (w_lr[gi]),
                .i_fire (w_fire),
                .i_data (i_data[gi*WIDTH +: WIDTH]),
                .o_la   (la[gi]),
                .o_full (w_full[gi]),
                .o_buf  (w_buf[gi])
            );
        end
    endgenerate

    // Masked bitwise reductions across the buffered tokens.
    always_comb begin
        w_and = '1;
        w_or  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (A_MASK[i]) w_and = w_and & w_buf[i];
            if (B_MASK[i]) w_or  = w_or  | w_buf[i];
        end
    end

    // Result registers and the two independent output handshake FSMs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_a <= O_IDLE;
            r_st_b <= O_IDLE;
            r_rr_a <= 1'b0;
            r_rr_b <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            if (w_fire) begin
                r_a <= w_and;
                r_b <= w_or;
            end
            case (r_st_a)
                O_IDLE: if (w_fire) begin r_st_a <= O_REQ;  r_rr_a <= 1'b1; end
                O_REQ:  if (w_ra_a) begin r_st_a <= O_RTZ;  r_rr_a <= 1'b0; end
                O_RTZ:  if (!w_ra_a)      r_st_a <= O_IDLE;
                default: begin r_st_a <= O_IDLE; r_rr_a <= 1'b0; end
            endcase
            case (r_st_b)
                O_IDLE: if (w_fire) begin r_st_b <= O_REQ;  r_rr_b <= 1'b1; end
                O_REQ:  if (w_ra_b) begin r_st_b <= O_RTZ;  r_rr_b <= 1'b0; end
                O_RTZ:  if (!w_ra_b)      r_st_b <= O_IDLE;
                default: begin r_st_b <= O_IDLE; r_rr_b <= 1'b0; end
            endcase
        end
    end

    assign rr_a = r_rr_a;
    assign rr_b = r_rr_b;
    assign a    = r_a;
    assign b    = r_b;
endmodule

// File: tb/tb_join_fork_sync_n.sv
// Directed bench for join_fork_sync_n with default parameters.
// The bench drives all inputs 1 time unit after a rising edge and samples the
// outputs at that same point.
module tb_join_fork_sync_n;
`ifdef JOIN_FORK_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] lr;
    logic [2:0] la;
    logic [2:0] i_data;
    logic       rr_a, ra_a, rr_b, ra_b;
    logic [0:0] a, b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] data;   // {in2,in1,in0}
        logic       exp_a;
        logic       exp_b;
    } vec_t;

    vec_t vecs [8];

    join_fork_sync_n dut (
        .clk(clk), .rst_n(rst_n), .lr(lr), .la(la), .i_data(i_data),
        .rr_a(rr_a), .ra_a(ra_a), .a(a), .rr_b(rr_b), .ra_b(ra_b), .b(b)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Complete both output handshakes, with a bounded wait for rr to drop.
    task automatic finish_out();
        int budget;
        lr   = 3'b000;
        ra_a = 1'b1;
        ra_b = 1'b1;
        budget = 20;
        while ((rr_a || rr_b) && budget > 0) begin
            tick(1);
            budget--;
        end
        check("finish_rr_drop_timeout", {7'd0, (budget > 0)}, 8'd1);
        ra_a = 1'b0;
        ra_b = 1'b0;
        tick(SL + 2);
    endtask

    // Full token: capture, fire, check results and timing, then return to zero.
    task automatic do_token(input vec_t v, input int idx);
        string s;
        s = $sformatf("vec%0d", idx);
        i_data = v.data;
        lr     = 3'b111;
        tick(SL + 1);
        check({s, "_la"}, {5'd0, la}, 8'h07);
        check({s, "_rr_early"}, {6'd0, rr_a, rr_b}, 8'h00);
        tick(1);
        check({s, "_rr"}, {6'd0, rr_a, rr_b}, 8'h03);
        check({s, "_a"}, {7'd0, a}, {7'd0, v.exp_a});
        check({s, "_b"}, {7'd0, b}, {7'd0, v.exp_b});
        lr   = 3'b000;
        ra_a = 1'b1;
        ra_b = 1'b1;
        tick(SL + 1);
        check({s, "_rtz"}, {5'd0, rr_a, rr_b, |la}, 8'h00);
        ra_a = 1'b0;
        ra_b = 1'b0;
        tick(SL + 2);
    endtask

    initial begin
        // Expected values: a = in0&in1&in2, b = in0|in2.
        vecs[0] = '{3'b111, 1'b1, 1'b1};
        vecs[1] = '{3'b001, 1'b0, 1'b1};
        vecs[2] = '{3'b010, 1'b0, 1'b0};
        vecs[3] = '{3'b100, 1'b0, 1'b1};
        vecs[4] = '{3'b000, 1'b0, 1'b0};
        vecs[5] = '{3'b110, 1'b0, 1'b1};
        vecs[6] = '{3'b011, 1'b0, 1'b1};
        vecs[7] = '{3'b101, 1'b0, 1'b1};

        // Reset with random inputs.
        rst_n  = 1'b0;
        lr     = 3'($urandom);
        i_data = 3'($urandom);
        ra_a   = 1'($urandom);
        ra_b   = 1'($urandom);
        tick(3);
        check("reset_outs", {1'b0, la, rr_a, rr_b, a, b}, 8'h00);
        lr   = 3'b000;
        ra_a = 1'b0;
        ra_b = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("idle_after_reset", {1'b0, la, rr_a, rr_b, a, b}, 8'h00);
        end

        // Table-driven tokens.
        for (int i = 0; i < 8; i++) do_token(vecs[i], i);

        // Staggered requests on cycles 0, 3 and 10: fire on edge 11.
        i_data = 3'b011;
        for (int c = 0; c <= 13 + SL; c++) begin
            if (c == 0)  lr[0] = 1'b1;
            if (c == 3)  lr[1] = 1'b1;
            if (c == 10) lr[2] = 1'b1;
            tick(1);
            check($sformatf("stagger_rr_c%0d", c), {6'd0, rr_a, rr_b},
                  (c >= 11 + SL) ? 8'h03 : 8'h00);
        end
        check("stagger_a", {7'd0, a}, 8'h00);
        check("stagger_b", {7'd0, b}, 8'h01);
        finish_out();

        // Back-pressure on b while a second token is captured.
        i_data = 3'b111;
        lr = 3'b111;
        tick(SL + 2);
        check("bp_fire1", {6'd0, rr_a, rr_b}, 8'h03);
        lr   = 3'b000;
        ra_a = 1'b1;
        tick(SL + 1);
        check("bp_a_rtz", {7'd0, rr_a}, 8'h00);
        ra_a = 1'b0;
        tick(SL + 1);
        i_data = 3'b000;
        lr = 3'b111;
        tick(SL + 1);
        check("bp_la_up", {5'd0, la}, 8'h07);
        lr = 3'b000;
        tick(SL + 1);
        check("bp_la_down", {5'd0, la}, 8'h00);
        for (int c = 0; c < 30; c++) begin
            tick(1);
            check("bp_stall", {5'd0, rr_a, rr_b, a}, 8'h03);
        end
        ra_b = 1'b1;
        tick(SL + 1);
        check("bp_b_rtz", {6'd0, rr_a, rr_b}, 8'h00);
        ra_b = 1'b0;
        tick(SL + 1);
        check("bp_no_fire_yet", {6'd0, rr_a, rr_b}, 8'h00);
        tick(1);
        check("bp_fire2", {4'd0, rr_a, rr_b, a, b}, 8'h0C);
        finish_out();

        // Reset mid-operation: rr_a high and two buffers full.
        i_data = 3'b111;
        lr = 3'b111;
        tick(SL + 2);
        lr = 3'b000;
        tick(SL + 1);
        lr = 3'b011;
        tick(SL + 1);
        check("mid_rr_a", {7'd0, rr_a}, 8'h01);
        check("mid_la", {5'd0, la}, 8'h03);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_async", {1'b0, la, rr_a, rr_b, a, b}, 8'h00);
        lr = 3'b000;
        tick(2);
        rst_n = 1'b1;
        i_data = 3'b101;
        lr = 3'b011;
        for (int c = 0; c < 6 + SL; c++) begin
            tick(1);
            check("post_reset_partial", {6'd0, rr_a, rr_b}, 8'h00);
        end
        lr = 3'b111;
        tick(SL + 1);
        check("post_reset_la", {5'd0, la}, 8'h07);
        tick(1);
        check("post_reset_fire", {4'd0, rr_a, rr_b, a, b}, 8'h0D);
        finish_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
